fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer uses a valid/ready handshake. The arbiter grants one owner for a burst of up to MAX_BURST beats, then drives the FIFO w_en/data_in port. Each word is tagged with its source ID so the consumer can demultiplex. Sits directly in front of synchronous_FIFO; its FIFO data width is WIDTH+ID_W.

---
 rtl/fifo_wr_arbiter_pkg.sv | 19 +
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
// The state enum, the round-robin pointer step and the source-ID width derivation live here.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Never narrower than one bit, so a tag field always exists.
   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int next_rr(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake bundle and FIFO write-port bundle seen by the arbiter.
// The master modport is the arbiter; the slave modport is the producers plus the FIFO.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int ID_W    = id_width(NUM_REQ)
);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     fifo_full;
   logic                     fifo_w_en;
   logic [WIDTH+ID_W-1:0]    fifo_data_in;
   logic                     grant_valid;
   logic [ID_W-1:0]          grant_id;

   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_w_en, fifo_data_in, grant_valid, grant_id
   );

   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_w_en, fifo_data_in, grant_valid, grant_id
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set bit of valid at or after ptr, wrapping.
// Shared by the idle pick and the end-of-burst pick in the arbiter.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   int j;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      found = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && valid[j]) begin
            found = 1'b1;
            idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// An owner keeps the port for up to MAX_BURST beats; each word is tagged with its source ID.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   fifo_wr_arbiter_if.master  bus
);

   localparam int ID_W  = id_width(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   arb_state_e       state_q, state_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  grant_id_q, grant_id_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             grant_valid_q, grant_valid_d;

   logic [ID_W-1:0]  owner_next;
   logic [ID_W-1:0]  pick_ptr;
   logic [ID_W-1:0]  pick_idx;
   logic             pick_found;
   logic             in_grant;
   logic             owner_valid;
   logic             owner_ready;
   logic             beat;
   logic             release_burst;

   // Idle searches from rr_ptr; at the end of a burst the search starts just past the owner,
   // which is the rr_ptr value being written that same cycle.
   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_pick (
      .valid (bus.req_valid),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      in_grant      = (state_q == GRANT);
      owner_next    = ID_W'(next_rr(int'(owner_q), NUM_REQ));
      pick_ptr      = in_grant ? owner_next : rr_ptr_q;
      owner_valid   = bus.req_valid[owner_q];
      owner_ready   = rst_n && in_grant && !bus.fifo_full;
      beat          = owner_valid && owner_ready;
      release_burst = in_grant && (!owner_valid || (beat && (beat_cnt_q == LAST_BEAT)));
   end

   always_comb begin
      bus.req_ready = '0;
      if (owner_ready) bus.req_ready[owner_q] = 1'b1;
   end

   assign bus.fifo_w_en    = beat;
   assign bus.fifo_data_in = {owner_q, bus.req_data[int'(owner_q)*WIDTH +: WIDTH]};
   assign bus.grant_valid  = grant_valid_q;
   assign bus.grant_id     = grant_id_q;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d    = GRANT;
               owner_d    = pick_idx;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            if (beat) beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (release_burst) begin
               rr_ptr_d   = owner_next;
               beat_cnt_d = '0;
               // Handover without a bubble; the old owner only re-wins when it is alone.
               if (pick_found) begin
                  owner_d = pick_idx;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      grant_valid_d = (state_d == GRANT);
      grant_id_d    = (state_d == GRANT) ? owner_d : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         owner_q       <= '0;
         rr_ptr_q      <= '0;
         beat_cnt_q    <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
      end else begin
         // NOTE: registers take non-blocking assignments; the combinational blocks above use blocking.
         state_q       <= state_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         beat_cnt_q    <= beat_cnt_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed sequences, a cycle table, and random traffic
// compared against a grant-level reference model.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int NR   = 4;
   localparam int W    = 8;
   localparam int MAXB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ   (NR),
      .WIDTH     (W),
      .MAX_BURST (MAXB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who holds the port, how many beats it has had, where the next search starts.
   int m_active, m_owner, m_beats, m_ptr;

   task automatic model_reset();
      m_active = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
   endtask

   function automatic int m_pick(input logic [3:0] v, input int start);
      for (int k = 0; k < NR; k++) begin
         if (v[(start + k) % NR]) return (start + k) % NR;
      end
      return -1;
   endfunction

   task automatic model_eval(input logic [3:0] v, input logic [31:0] d, input logic full,
                             output logic [3:0] rdy, output logic wen, output logic [9:0] dat,
                             output logic gv, output logic [1:0] gid);
      rdy = '0; wen = 1'b0; dat = '0; gv = 1'b0; gid = '0;
      if (m_active != 0) begin
         gv  = 1'b1;
         gid = 2'(m_owner);
         if (!full) rdy[m_owner] = 1'b1;
         wen = v[m_owner] && !full;
         dat = {2'(m_owner), d[m_owner*8 +: 8]};
      end
   endtask

   task automatic model_step(input logic [3:0] v, input logic full);
      int p;
      bit rel;
      rel = 1'b0;
      if (m_active == 0) begin
         p = m_pick(v, m_ptr);
         if (p >= 0) begin m_active = 1; m_owner = p; m_beats = 0; end
      end else begin
         if (!v[m_owner]) rel = 1'b1;
         else if (!full) begin
            m_beats++;
            if (m_beats == MAXB) rel = 1'b1;
         end
         if (rel) begin
            m_ptr = (m_owner + 1) % NR;
            p = m_pick(v, m_ptr);
            if (p >= 0) begin m_owner = p; m_beats = 0; end
            else m_active = 0;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] v;
      logic       full;
      logic [3:0] rdy;
      logic       wen;
      logic       gv;
      logic [1:0] gid;
      logic [1:0] id;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tdata;
      logic [3:0]  v, acc_prev, v_prev, e_rdy;
      logic [31:0] d_cur;
      logic        full, e_wen, e_gv;
      logic [9:0]  e_dat;
      logic [1:0]  e_gid;
      logic [7:0]  b;

      bus.req_valid = '0; bus.req_data = '0; bus.fifo_full = 1'b0;

      // Reset held with every producer asking.
      @(negedge clk);
      rst_n = 1'b0; bus.req_valid = 4'hF; bus.req_data = 32'h44332211;
      #1;
      check("reset req_ready", 32'(bus.req_ready), 32'h0);
      check("reset w_en", 32'(bus.fifo_w_en), 32'h0);
      check("reset grant_valid", 32'(bus.grant_valid), 32'h0);
      check("reset grant_id", 32'(bus.grant_id), 32'h0);
      @(negedge clk); rst_n = 1'b1; #1;
      check("release idle grant_valid", 32'(bus.grant_valid), 32'h0);
      @(negedge clk); #1;
      check("release grant_valid", 32'(bus.grant_valid), 32'h1);
      check("release grant_id", 32'(bus.grant_id), 32'h0);

      // Single producer 2, streaming 0x10, 0x11, ...
      do_reset();
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         rst_n = 1'b1;
         b = 8'(16 + ((k == 0) ? 0 : k - 1));
         bus.req_valid = 4'b0100;
         bus.req_data  = {8'h00, b, 16'h0000};
         #1;
         if (k == 0) begin
            check("single first w_en", 32'(bus.fifo_w_en), 32'h0);
         end else begin
            check($sformatf("single w_en k=%0d", k), 32'(bus.fifo_w_en), 32'h1);
            check($sformatf("single data k=%0d", k), 32'(bus.fifo_data_in), 32'h210 + 32'(k - 1));
            check($sformatf("single gid k=%0d", k), 32'(bus.grant_id), 32'h2);
         end
      end

      // All four producers streaming: bursts of four in ID order.
      do_reset();
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         rst_n = 1'b1;
         bus.req_valid = 4'hF;
         bus.req_data  = 32'hD3C2B1A0;
         #1;
         if (k == 0) begin
            check("all4 first w_en", 32'(bus.fifo_w_en), 32'h0);
         end else begin
            check($sformatf("all4 w_en k=%0d", k), 32'(bus.fifo_w_en), 32'h1);
            check($sformatf("all4 id k=%0d", k), 32'(bus.fifo_data_in[9:8]), 32'(((k - 1) / 4) % 4));
         end
      end

      // Cycle table: full stall during req1's burst, owner drop, reset mid-burst.
      tdata = 32'h3D2C1B0A;
      //                 rst   v        full  rdy      wen   gv    gid    id
      tbl.push_back(vec_t'{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 2'd1});
      tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 2'd1});
      tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0110, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 2'd1});
      tbl.push_back(vec_t'{1'b1, 4'b0110, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 2'd1});
      tbl.push_back(vec_t'{1'b1, 4'b0110, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 2'd2});
      tbl.push_back(vec_t'{1'b0, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b1001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b1000, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 2'd3});
      tbl.push_back(vec_t'{1'b1, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 2'd1});
      tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 2'd1});
      tbl.push_back(vec_t'{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 2'd0});
      tbl.push_back(vec_t'{1'b1, 4'b0011, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 2'd1});

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst_n         = tbl[i].rst;
         bus.req_valid = tbl[i].v;
         bus.fifo_full = tbl[i].full;
         bus.req_data  = tdata;
         #1;
         check($sformatf("tbl[%0d] req_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
         check($sformatf("tbl[%0d] w_en", i), 32'(bus.fifo_w_en), 32'(tbl[i].wen));
         check($sformatf("tbl[%0d] grant_valid", i), 32'(bus.grant_valid), 32'(tbl[i].gv));
         check($sformatf("tbl[%0d] grant_id", i), 32'(bus.grant_id), 32'(tbl[i].gid));
         if (tbl[i].wen) begin
            b = tdata[tbl[i].id*8 +: 8];
            check($sformatf("tbl[%0d] data", i), 32'(bus.fifo_data_in), 32'({tbl[i].id, b}));
         end
      end

      // Random traffic; producers keep data stable while waiting but may give up.
      do_reset();
      v_prev = '0; acc_prev = '0; d_cur = '0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         rst_n = 1'b1;
         for (int i = 0; i < NR; i++) begin
            if (v_prev[i] && !acc_prev[i]) begin
               v[i] = ($urandom_range(9) != 0);
            end else begin
               v[i] = ($urandom_range(2) != 0);
               d_cur[i*8 +: 8] = 8'($urandom);
            end
         end
         full = ($urandom_range(3) == 0);
         bus.req_valid = v; bus.req_data = d_cur; bus.fifo_full = full;
         #1;
         model_eval(v, d_cur, full, e_rdy, e_wen, e_dat, e_gv, e_gid);
         check($sformatf("rand[%0d] req_ready", k), 32'(bus.req_ready), 32'(e_rdy));
         check($sformatf("rand[%0d] w_en", k), 32'(bus.fifo_w_en), 32'(e_wen));
         check($sformatf("rand[%0d] grant_valid", k), 32'(bus.grant_valid), 32'(e_gv));
         check($sformatf("rand[%0d] grant_id", k), 32'(bus.grant_id), 32'(e_gid));
         if (e_wen) check($sformatf("rand[%0d] data", k), 32'(bus.fifo_data_in), 32'(e_dat));
         acc_prev = e_rdy & v;
         v_prev   = v;
         model_step(v, full);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
